// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO unit: op-codes, FSM encoding, request record
// and the two's-complement helper used for magnitude/sign conversion.
package hilo_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  localparam int DIV_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_FIX,
    ST_DRAIN
  } state_t;

  // Operands handed to the unsigned divider plus the sign fix-up to apply later.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        neg_q;
    logic        neg_r;
  } div_req_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/hilo_sign_fix.sv
// One operand lane of sign handling: absolute value on the way into the divider,
// conditional negation of the divider result on the way back.
module hilo_sign_fix
  import hilo_pkg::*;
(
  input  logic [31:0] i_mag_in,
  input  logic        i_mag_signed,
  output logic [31:0] o_mag,
  input  logic [31:0] i_fix_in,
  input  logic        i_fix_neg,
  output logic [31:0] o_fix
);

  // 0x80000000 negates to itself, which is exactly the magnitude the divider needs.
  assign o_mag = (i_mag_signed && i_mag_in[31]) ? neg32(i_mag_in) : i_mag_in;
  assign o_fix = i_fix_neg ? neg32(i_fix_in) : i_fix_in;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner: screens divide requests, drives the external unsigned
// divider, sign-corrects its result and commits HI (remainder) / LO (quotient).
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_op_valid,
  input  logic [2:0]  i_op_code,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  input  logic        i_op_abort,
  output logic        o_op_ready,
  output logic        o_busy,
  output logic [31:0] o_hi_out,
  output logic [31:0] o_lo_out,
  output logic        o_div_zero_exc,
  output logic        o_div_timeout,
  output logic        o_div_start,
  output logic [31:0] o_div_a,
  output logic [31:0] o_div_b,
  input  logic        i_div_done,
  input  logic [31:0] i_div_q,
  input  logic [31:0] i_div_r
);

  localparam int CW = $clog2(DIV_TIMEOUT + 2);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [31:0]     r_hi, r_lo, r_q, r_r;
  div_req_t        r_req;
  logic            r_busy, r_zero_exc, r_timeout, w_timeout_nxt;
  logic            w_accept, w_is_div, w_signed, w_rt_zero, w_launch, w_expire;
  logic [31:0]     w_a_mag, w_b_mag, w_lo_fix, w_hi_fix;

  assign w_accept  = i_op_valid && (r_state == ST_IDLE);
  assign w_is_div  = (i_op_code == OP_DIV) || (i_op_code == OP_DIVU);
  assign w_signed  = (i_op_code == OP_DIV);
  assign w_rt_zero = (i_rt_val == 32'd0);
  assign w_launch  = w_accept && w_is_div && !w_rt_zero;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_expire  = (w_cnt_inc >= CW'(DIV_TIMEOUT));

  // Lane 0 carries dividend -> quotient, lane 1 carries divisor -> remainder.
  hilo_sign_fix u_fix_q (
    .i_mag_in    (i_rs_val),
    .i_mag_signed(w_signed),
    .o_mag       (w_a_mag),
    .i_fix_in    (r_q),
    .i_fix_neg   (r_req.neg_q),
    .o_fix       (w_lo_fix)
  );

  hilo_sign_fix u_fix_r (
    .i_mag_in    (i_rt_val),
    .i_mag_signed(w_signed),
    .o_mag       (w_b_mag),
    .i_fix_in    (r_r),
    .i_fix_neg   (r_req.neg_r),
    .o_fix       (w_hi_fix)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) w_state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        w_cnt_nxt   = '0;
        w_state_nxt = i_op_abort ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (i_div_done) begin
          // An abort coinciding with completion simply drops the result.
          w_state_nxt = i_op_abort ? ST_IDLE : ST_FIX;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (i_op_abort) begin
            w_state_nxt = ST_DRAIN;
          end else if (w_expire) begin
            w_state_nxt   = ST_IDLE;
            w_timeout_nxt = 1'b1;
          end
        end
      end
      ST_FIX: w_state_nxt = ST_IDLE;
      ST_DRAIN: begin
        if (i_div_done || w_expire) w_state_nxt = ST_IDLE;
        else                        w_cnt_nxt   = w_cnt_inc;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_zero_exc <= 1'b0;
      r_timeout  <= 1'b0;
      r_req      <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_zero_exc <= w_accept && w_is_div && w_rt_zero;
      r_timeout  <= w_timeout_nxt;
      if (w_launch) begin
        r_req.a     <= w_a_mag;
        r_req.b     <= w_b_mag;
        r_req.neg_q <= w_signed && (i_rs_val[31] ^ i_rt_val[31]);
        r_req.neg_r <= w_signed && i_rs_val[31];
      end
      if ((r_state == ST_WAIT) && i_div_done) begin
        r_q <= i_div_q;
        r_r <= i_div_r;
      end
      if (w_accept && (i_op_code == OP_MTHI)) r_hi <= i_rs_val;
      if (w_accept && (i_op_code == OP_MTLO)) r_lo <= i_rs_val;
      if (r_state == ST_FIX) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end
    end
  end

  assign o_op_ready     = (r_state == ST_IDLE);
  assign o_busy         = r_busy;
  assign o_div_start    = (r_state == ST_LAUNCH);
  assign o_div_a        = r_req.a;
  assign o_div_b        = r_req.b;
  assign o_hi_out       = r_hi;
  assign o_lo_out       = r_lo;
  assign o_div_zero_exc = r_zero_exc;
  assign o_div_timeout  = r_timeout;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: behavioural divider stub, directed vector table, random ops
// against an arithmetic HI/LO model, and abort / watchdog / reset sequences.
module tb_hilo_unit;
  import hilo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, op_valid, op_abort;
  logic [2:0]  op_code;
  logic [31:0] rs_val, rt_val;
  logic        op_ready, busy, div_zero_exc, div_timeout, div_start;
  logic [31:0] hi_out, lo_out, div_a, div_b;
  logic        div_done;
  logic [31:0] div_q, div_r;

  logic        stub_done, stub_act, inj_done;
  logic [31:0] stub_q, stub_r, inj_q, inj_r, sa, sb;
  int          stub_cnt;
  int          stub_lat;
  bit          stub_mute;

  assign div_done = stub_done | inj_done;
  assign div_q    = inj_done ? inj_q : stub_q;
  assign div_r    = inj_done ? inj_r : stub_r;

  hilo_unit #(.DIV_TIMEOUT(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_op_valid(op_valid), .i_op_code(op_code),
    .i_rs_val(rs_val), .i_rt_val(rt_val), .i_op_abort(op_abort),
    .o_op_ready(op_ready), .o_busy(busy), .o_hi_out(hi_out), .o_lo_out(lo_out),
    .o_div_zero_exc(div_zero_exc), .o_div_timeout(div_timeout),
    .o_div_start(div_start), .o_div_a(div_a), .o_div_b(div_b),
    .i_div_done(div_done), .i_div_q(div_q), .i_div_r(div_r)
  );

  // Unsigned divider stub sharing the same reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_done <= 1'b0; stub_act <= 1'b0; stub_cnt <= 0;
      stub_q <= '0; stub_r <= '0; sa <= '0; sb <= 32'd1;
    end else begin
      stub_done <= 1'b0;
      if (div_start) begin
        stub_act <= !stub_mute;
        stub_cnt <= stub_lat;
        sa <= div_a;
        sb <= div_b;
      end else if (stub_act) begin
        if (stub_cnt <= 1) begin
          stub_done <= 1'b1;
          stub_q    <= sa / sb;
          stub_r    <= sa % sb;
          stub_act  <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] v, input bit sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  // Reference: signed/unsigned 64-bit arithmetic, truncated to the 32-bit registers.
  task automatic model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint sd, sv, q, r;
    case (op)
      OP_MTHI: m_hi = rs;
      OP_MTLO: m_lo = rs;
      OP_DIV: if (rt != 0) begin
        sd = longint'($signed(rs)); sv = longint'($signed(rt));
        q = sd / sv; r = sd % sv;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      OP_DIVU: if (rt != 0) begin
        sd = longint'({32'd0, rs}); sv = longint'({32'd0, rt});
        q = sd / sv; r = sd % sv;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      default: ;
    endcase
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!div_done && t < 200) begin @(negedge clk); t++; end
    chk({name, "_done_seen"}, {31'd0, div_done}, 32'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    op_valid = 1'b1; op_code = op; rs_val = rs; rt_val = rt;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Runs one request end to end and checks the handshake timing around it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bit isdiv = (op == OP_DIV) || (op == OP_DIVU);
    int starts = 0;
    int t = 0;
    chk("ready_before", {31'd0, op_ready}, 32'd1);
    issue(op, rs, rt);
    if (isdiv && rt != 0) begin
      chk("start_c1", {31'd0, div_start}, 32'd1);
      chk("div_a", div_a, mag(rs, op == OP_DIV));
      chk("div_b", div_b, mag(rt, op == OP_DIV));
      chk("busy_c1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      while (!div_done && t < 200) begin
        if (div_start) starts++;
        @(negedge clk); t++;
      end
      chk("done_seen", {31'd0, div_done}, 32'd1);
      chk("start_once", starts, 0);
      @(negedge clk);
      chk("busy_k1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("ready_k2", {31'd0, op_ready}, 32'd1);
      chk("busy_k2", {31'd0, busy}, 32'd0);
    end else if (isdiv) begin
      chk("zexc_c1", {31'd0, div_zero_exc}, 32'd1);
      chk("zstart_c1", {31'd0, div_start}, 32'd0);
      chk("zready_c1", {31'd0, op_ready}, 32'd1);
      @(negedge clk);
      chk("zexc_c2", {31'd0, div_zero_exc}, 32'd0);
    end else begin
      chk("mt_ready_c1", {31'd0, op_ready}, 32'd1);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt, hi, lo;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{OP_DIV,  32'd100,        32'd7,          32'd2,          32'd14};
    tbl[1] = '{OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD};
    tbl[2] = '{OP_DIVU, 32'hFFFFFFFF,   32'h10,         32'hF,          32'h0FFFFFFF};
    tbl[3] = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
    tbl[4] = '{OP_MTHI, 32'h1234,       32'd0,          32'h1234,       32'h80000000};
    tbl[5] = '{OP_DIV,  32'd5,          32'd0,          32'h1234,       32'h80000000};
    tbl[6] = '{OP_MTLO, 32'hCAFE,       32'd9,          32'h1234,       32'hCAFE};
    tbl[7] = '{OP_DIV,  32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD};
    tbl[8] = '{3'd5,    32'hDEAD,       32'hBEEF,       32'd1,          32'hFFFFFFFD};
    tbl[9] = '{OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};

    rst_n = 1'b0; op_valid = 1'b0; op_abort = 1'b0; op_code = '0;
    rs_val = '0; rt_val = '0; inj_done = 1'b0; inj_q = '0; inj_r = '0;
    stub_lat = 3; stub_mute = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, div_start}, 32'd0);
    chk("rst_ab", div_a | div_b, 32'd0);
    chk("rst_pulses", {30'd0, div_zero_exc, div_timeout}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      stub_lat = 1 + i;
      run_op(tbl[i].op, tbl[i].rs, tbl[i].rt);
      chk($sformatf("tbl%0d_hi", i), hi_out, tbl[i].hi);
      chk($sformatf("tbl%0d_lo", i), lo_out, tbl[i].lo);
    end
    m_hi = tbl[9].hi; m_lo = tbl[9].lo;

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op = 3'($urandom_range(0, 7));
      logic [31:0] rs = $urandom;
      logic [31:0] rt = ($urandom_range(0, 7) == 0) ? 32'd0 :
                        ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 40)) - 32'd20 : $urandom;
      if ($urandom_range(0, 2) == 0) op = 3'($urandom_range(1, 2));
      stub_lat = $urandom_range(1, 12);
      run_op(op, rs, rt);
      model(op, rs, rt);
      chk($sformatf("rnd%0d_hi", i), hi_out, m_hi);
      chk($sformatf("rnd%0d_lo", i), lo_out, m_lo);
    end

    // Abort in WAIT: divider answers later, result must be dropped.
    run_op(OP_MTHI, 32'hAAAA5555, 32'd0); model(OP_MTHI, 32'hAAAA5555, 32'd0);
    run_op(OP_MTLO, 32'h5555AAAA, 32'd0); model(OP_MTLO, 32'h5555AAAA, 32'd0);
    stub_lat = 12;
    issue(OP_DIV, 32'd50, 32'd3);
    @(negedge clk);
    op_abort = 1'b1;
    @(negedge clk);
    op_abort = 1'b0;
    chk("ab_busy_drain", {31'd0, busy}, 32'd1);
    wait_done("ab");
    @(negedge clk);
    chk("ab_busy_after", {31'd0, busy}, 32'd0);
    chk("ab_ready_after", {31'd0, op_ready}, 32'd1);
    @(negedge clk);
    chk("ab_hi", hi_out, m_hi);
    chk("ab_lo", lo_out, m_lo);

    // Abort in LAUNCH: start still issued, result dropped.
    stub_lat = 5;
    issue(OP_DIVU, 32'd77, 32'd5);
    op_abort = 1'b1;
    chk("abl_start", {31'd0, div_start}, 32'd1);
    @(negedge clk);
    op_abort = 1'b0;
    chk("abl_ready", {31'd0, op_ready}, 32'd0);
    wait_done("abl");
    repeat (2) @(negedge clk);
    chk("abl_hi", hi_out, m_hi);
    chk("abl_lo", lo_out, m_lo);
    chk("abl_ready2", {31'd0, op_ready}, 32'd1);

    // Watchdog: silent divider, 64 WAIT cycles then timeout pulse.
    begin
      int n = 0;
      stub_mute = 1'b1;
      issue(OP_DIV, 32'd9, 32'd4);
      do begin @(negedge clk); n++; end while (!div_timeout && n < 200);
      chk("to_cycles", n, 65);
      chk("to_ready", {31'd0, op_ready}, 32'd1);
      chk("to_hi", hi_out, m_hi);
      chk("to_lo", lo_out, m_lo);
      @(negedge clk);
      chk("to_pulse_end", {31'd0, div_timeout}, 32'd0);
      stub_mute = 1'b0;
    end

    // Reset in WAIT, then a stray completion after release.
    stub_lat = 30;
    issue(OP_DIV, 32'd1000, 32'd10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_hi", hi_out, 32'd0);
    chk("mr_lo", lo_out, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_ready", {31'd0, op_ready}, 32'd1);
    chk("mr_start_ab", {31'd0, div_start} | div_a | div_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    inj_done = 1'b1; inj_q = 32'd5; inj_r = 32'd6;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    chk("late_hi", hi_out, 32'd0);
    chk("late_lo", lo_out, 32'd0);
    chk("late_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

- Sits between decode/execute and the unsigned iterative divider, and owns the architectural HI/LO registers.
- Accepts DIV/DIVU/MTHI/MTLO requests and screens out divide-by-zero.
- For signed division, converts operands to magnitudes, starts the divider with a one-cycle pulse and waits for completion, then sign-corrects and commits HI (remainder) and LO (quotient).
- Stalls MFHI/MFLO through `busy`; supports a pipeline flush and a completion watchdog.

## Interface
- `DIV_TIMEOUT`, 64: cycles WAIT/DRAIN tolerate without `div_done` before giving up.
- `clk` in 1: sole clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `op_valid` in 1: request strobe; accepted only when `op_ready`=1.
- `op_code` in 3: 0 NOP, 1 DIV, 2 DIVU, 3 MTHI, 4 MTLO, others treated as NOP.
- `rs_val` in 32: dividend / MTHI/MTLO source.
- `rt_val` in 32: divisor.
- `op_abort` in 1: flush; kills an in-flight division.
- `op_ready` out 1: high only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `hi_out`, `lo_out` out 32: current HI/LO.
- `div_zero_exc` out 1: one-cycle pulse on DIV/DIVU with `rt_val`==0.
- `div_timeout` out 1: one-cycle pulse on watchdog expiry.
- `div_start` out 1: one-cycle launch pulse to the divider.
- `div_a`, `div_b` out 32: unsigned operands, held stable from LAUNCH until leaving WAIT.
- `div_done` in 1: divider completion pulse.
- `div_q`, `div_r` in 32: unsigned quotient/remainder, valid with `div_done`.

## Operation
- States: IDLE, LAUNCH, WAIT, FIX, DRAIN.
- **IDLE**, on an accepted request:
  - MTHI/MTLO: write `rs_val` to HI/LO at that edge; stay in IDLE.
  - DIV/DIVU with `rt_val`==0: pulse `div_zero_exc` next cycle, leave HI/LO unchanged, no `div_start`; stay in IDLE.
  - DIV/DIVU with `rt_val`!=0: register the magnitudes into `div_a`/`div_b` (DIVU passes values through; DIV takes two's-complement absolute values, with 0x80000000 staying 0x80000000), register `neg_q` = sign(rs)^sign(rt) and `neg_r` = sign(rs) (both 0 for DIVU), then go to LAUNCH.
- **LAUNCH**: assert `div_start` for exactly one cycle, clear the watchdog counter, go to WAIT.
- **WAIT**:
  - On `div_done`, capture `div_q`/`div_r` and go to FIX.
  - Otherwise increment the counter; when it reaches `DIV_TIMEOUT`, pulse `div_timeout`, leave HI/LO unchanged, go to IDLE.
- **FIX**: LO = `neg_q` ? -q : q; HI = `neg_r` ? -r : r, written at this edge (32-bit wrap). Go to IDLE.
- **Abort**:
  - `op_abort` in LAUNCH or WAIT goes to DRAIN; in LAUNCH, `div_start` is still issued so the divider state is known.
  - In DRAIN, a `div_done` is discarded and the block returns to IDLE. The watchdog also runs in DRAIN; on expiry, go to IDLE without pulsing `div_timeout`.
  - `op_abort` in IDLE or FIX is ignored; FIX always commits.
- Overflow case: 0x80000000 DIV 0xFFFFFFFF gives LO=0x80000000, HI=0, no exception.
- A `div_done` seen outside WAIT/DRAIN is ignored.

## Timing
- Reset values: HI=LO=0, state IDLE, `op_ready`=1, `busy`=0, `div_start`=0, `div_a`=`div_b`=0, `div_zero_exc`=0, `div_timeout`=0, counter 0.
- Accept at edge 0; `div_start` high during cycle 1.
- Given `div_done` in cycle k, HI/LO are visible in cycle k+2 and `op_ready` is high in cycle k+2.
- MTHI/MTLO: new value visible the cycle after acceptance.
- `div_zero_exc` is high for the one cycle after acceptance.
- `busy` is registered, derived from state.
- `Reset` asserted mid-operation immediately returns all outputs to their reset values; the divider must be reset by the same `Reset`.

## Structure
- Shared package `hilo_pkg`: op-code constants (NOP, DIV, DIVU, MTHI, MTLO), state encoding, and a `neg32` two's-complement helper.
- One natural sub-module, `hilo_sign_fix`: combinational magnitude conversion on the input side and sign restoration on the output side, instantiated twice.

## Test plan
- DIV 100 / 7 -> `div_a`=100, `div_b`=7; stub returns q=14, r=2; LO=14, HI=2 at k+2.
- DIV 0xFFFFFFF9 (-7) / 2 -> `div_a`=7; stub returns q=3, r=1; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0xFFFFFFFF / 0x10 -> LO=0x0FFFFFFF, HI=0xF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1234 then DIV 5 / 0 -> `div_zero_exc` pulses once, no `div_start`, HI stays 0x1234, `op_ready` stays 1.
- DIV launched, `op_abort` in WAIT, stub `div_done` 10 cycles later -> HI/LO unchanged, `busy` drops the cycle after `div_done`; separately, stub never responds -> `div_timeout` pulses after 64 WAIT cycles.
- `Reset` asserted low in WAIT -> HI=LO=0 and `busy`=0 immediately; a late `div_done` after release is ignored.
